uplink_capture_ctrl: RTL and testbench

Capture controller in the clk40 domain, between the lpGBT uplink outputs and the write side of the dataframe FIFO. It qualifies 234-bit uplink frames and writes a bounded burst of them into the FIFO after an arm/trigger sequence. It optionally discards all-zero frames and counts frames lost to FIFO-full. Control inputs arrive already synchronised to clk40_i from the AXI register block.

---
 rtl/uplink_capture_ctrl.sv | 159 +++++++++++++++
 tb/tb_uplink_capture_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/uplink_capture_ctrl.sv
// ============================================================================
// uplink_capture_ctrl : qualifies lpGBT uplink frames and writes an armed,
// triggered, bounded burst of them into the dataframe FIFO (clk40 domain).
// Revision: 1.0
// ============================================================================
`default_nettype none

module uplink_capture_ctrl #(
  parameter int DATA_W = 234,
  parameter int CNT_W  = 16
) (
  input  logic              clk40_i,
  input  logic              resetn_i,
  input  logic [DATA_W-1:0] uplinkUserData_i,
  input  logic              uplinkrdy_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [1:0]        trig_mode_i,
  input  logic              trig_i,
  input  logic [31:0]       match_value_i,
  input  logic [31:0]       match_mask_i,
  input  logic              skip_zero_i,
  input  logic [CNT_W-1:0]  n_frames_i,
  input  logic              fifo_full_i,
  output logic [DATA_W-1:0] frame_o,
  output logic              frame_wr_o,
  output logic [1:0]        state_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  captured_o,
  output logic [CNT_W-1:0]  dropped_o,
  output logic              overflow_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [1:0] MODE_EXT   = 2'd1;
  localparam logic [1:0] MODE_MATCH = 2'd2;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   frame_q, frame_d;
  logic                frame_wr_q, frame_wr_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    captured_q, captured_d;
  logic [CNT_W-1:0]    dropped_q, dropped_d;
  logic                overflow_q, overflow_d;
  logic [CNT_W-1:0]    target_q, target_d;
  logic [1:0]          mode_q, mode_d;

  logic                valid;
  logic                match;
  logic                trigger;
  logic                qualify;
  logic [CNT_W-1:0]    captured_inc;

  assign valid   = uplinkrdy_i && !(skip_zero_i && (uplinkUserData_i == '0));
  assign match   = (((uplinkUserData_i[31:0] ^ match_value_i) & match_mask_i) == 32'd0);
  // Trigger mode is latched at arm so a register write mid-capture cannot change it.
  assign trigger = valid && (((mode_q == MODE_EXT) && trig_i) ||
                             ((mode_q == MODE_MATCH) && match));
  assign captured_inc = captured_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    frame_wr_d = 1'b0;
    captured_d = captured_q;
    dropped_d  = dropped_q;
    overflow_d = overflow_q;
    target_d   = target_q;
    mode_d     = mode_q;
    qualify    = 1'b0;

    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm_i) begin
            captured_d = '0;
            dropped_d  = '0;
            overflow_d = 1'b0;
            target_d   = n_frames_i;
            mode_d     = trig_mode_i;
            if ((trig_mode_i == MODE_EXT) || (trig_mode_i == MODE_MATCH))
              state_d = S_ARMED;
            else
              state_d = S_CAPTURE;
          end
        end
        S_ARMED: begin
          if (trigger) begin
            qualify = 1'b1;
            state_d = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          qualify = valid;
        end
        default: state_d = S_IDLE;
      endcase

      if (qualify) begin
        if (!fifo_full_i) begin
          frame_d    = uplinkUserData_i;
          frame_wr_d = 1'b1;
          captured_d = captured_inc;
          if ((target_q != '0) && (captured_inc == target_q))
            state_d = S_DONE;
        end else begin
          if (dropped_q != '1)
            dropped_d = dropped_q + CNT_W'(1);
          overflow_d = 1'b1;
        end
      end
    end

    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk40_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      frame_wr_q <= 1'b0;
      done_q     <= 1'b0;
      captured_q <= '0;
      dropped_q  <= '0;
      overflow_q <= 1'b0;
      target_q   <= '0;
      mode_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      frame_wr_q <= frame_wr_d;
      done_q     <= done_d;
      captured_q <= captured_d;
      dropped_q  <= dropped_d;
      overflow_q <= overflow_d;
      target_q   <= target_d;
      mode_q     <= mode_d;
    end
  end

  assign frame_o    = frame_q;
  assign frame_wr_o = frame_wr_q;
  assign state_o    = state_q;
  assign done_o     = done_q;
  assign captured_o = captured_q;
  assign dropped_o  = dropped_q;
  assign overflow_o = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_uplink_capture_ctrl.sv
// ============================================================================
// tb_uplink_capture_ctrl : directed self-checking bench for uplink_capture_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uplink_capture_ctrl;

  localparam int DATA_W = 234;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] data;
  logic              rdy, arm, abort_p, trig, skip0, full;
  logic [1:0]        mode;
  logic [31:0]       mval, mmask;
  logic [CNT_W-1:0]  nfr;
  logic [DATA_W-1:0] frame;
  logic              wr, done, ovf;
  logic [1:0]        st;
  logic [CNT_W-1:0]  cap, drp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uplink_capture_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk40_i(clk), .resetn_i(rst_n), .uplinkUserData_i(data), .uplinkrdy_i(rdy),
    .arm_i(arm), .abort_i(abort_p), .trig_mode_i(mode), .trig_i(trig),
    .match_value_i(mval), .match_mask_i(mmask), .skip_zero_i(skip0),
    .n_frames_i(nfr), .fifo_full_i(full), .frame_o(frame), .frame_wr_o(wr),
    .state_o(st), .done_o(done), .captured_o(cap), .dropped_o(drp), .overflow_o(ovf)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: present current inputs, sample 1 time unit after the edge, clear pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    arm = 1'b0; abort_p = 1'b0; trig = 1'b0;
  endtask

  task automatic frame_in(input logic [DATA_W-1:0] d, input logic f);
    data = d; full = f;
    tick();
  endtask

  task automatic do_arm(input logic [1:0] m, input logic [CNT_W-1:0] n);
    mode = m; nfr = n; arm = 1'b1; data = '0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; data = '0; rdy = 1'b1; arm = 1'b0; abort_p = 1'b0; trig = 1'b0;
    skip0 = 1'b0; full = 1'b0; mode = 2'd0; mval = '0; mmask = '0; nfr = '0;
    #23;
    chk("rst_state", st, 0);   chk("rst_frame", frame, 0); chk("rst_wr", wr, 0);
    chk("rst_done", done, 0);  chk("rst_cap", cap, 0);     chk("rst_drp", drp, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Mode 0, four frames out of a counting stream.
    do_arm(2'd0, 16'd4);
    chk("m0_arm_state", st, 2);
    for (int k = 1; k <= 10; k++) begin
      frame_in(DATA_W'(k), 1'b0);
      chk("m0_wr", wr, (k <= 4));
      if (k <= 4) chk("m0_frame", frame, k);
    end
    chk("m0_cap", cap, 4); chk("m0_state", st, 3); chk("m0_done", done, 1);

    // Mode 2 pattern match on the low 16 bits.
    mval = 32'h0000ABCD; mmask = 32'h0000FFFF;
    do_arm(2'd2, 16'd2);
    chk("m2_arm_state", st, 1); chk("m2_done_clr", done, 0); chk("m2_cap_clr", cap, 0);
    frame_in(DATA_W'(32'h1111), 1'b0);
    chk("m2_nomatch_wr", wr, 0); chk("m2_nomatch_state", st, 1);
    frame_in(DATA_W'(32'h2222ABCD), 1'b0);
    chk("m2_trig_wr", wr, 1); chk("m2_trig_frame", frame, 32'h2222ABCD); chk("m2_trig_state", st, 2);
    frame_in(DATA_W'(3), 1'b0);
    chk("m2_2nd_wr", wr, 1); chk("m2_2nd_frame", frame, 3); chk("m2_cap", cap, 2);
    chk("m2_state", st, 3);

    // Mode 1: trigger without a ready frame is invisible; with one it fires.
    do_arm(2'd1, 16'd1);
    rdy = 1'b0; trig = 1'b1; frame_in(DATA_W'(9), 1'b0);
    chk("m1_notrig_wr", wr, 0); chk("m1_notrig_state", st, 1);
    rdy = 1'b1; frame_in(DATA_W'(8), 1'b0);
    chk("m1_notrig2_wr", wr, 0);
    trig = 1'b1; frame_in(DATA_W'(7), 1'b0);
    chk("m1_wr", wr, 1); chk("m1_frame", frame, 7); chk("m1_state", st, 3);

    // Skip-zero with alternating zero frames.
    skip0 = 1'b1;
    do_arm(2'd0, 16'd3);
    for (int k = 0; k < 6; k++) begin
      frame_in((k % 2 == 0) ? DATA_W'(0) : DATA_W'(5), 1'b0);
      chk("sz_wr", wr, (k % 2 == 1));
      if (k % 2 == 1) chk("sz_frame", frame, 5);
    end
    chk("sz_cap", cap, 3); chk("sz_state", st, 3);
    frame_in(DATA_W'(0), 1'b0);
    chk("sz_after_wr", wr, 0);
    skip0 = 1'b0;

    // FIFO full for two frames mid-capture.
    do_arm(2'd0, 16'd5);
    for (int k = 1; k <= 7; k++) begin
      frame_in(DATA_W'(k), (k == 2 || k == 3));
      chk("ff_wr", wr, !(k == 2 || k == 3));
    end
    chk("ff_drp", drp, 2); chk("ff_ovf", ovf, 1); chk("ff_cap", cap, 5); chk("ff_state", st, 3);
    frame_in(DATA_W'(8), 1'b0);
    chk("ff_done_hold_wr", wr, 0);
    do_arm(2'd0, 16'd5);
    chk("ff_rearm_drp", drp, 0); chk("ff_rearm_ovf", ovf, 0);

    // Continuous capture ended by abort with a simultaneous arm.
    abort_p = 1'b1; tick();
    do_arm(2'd0, 16'd0);
    for (int k = 1; k <= 7; k++) frame_in(DATA_W'(k), 1'b0);
    chk("ab_cap7", cap, 7); chk("ab_state_cap", st, 2);
    abort_p = 1'b1; arm = 1'b1; frame_in(DATA_W'(8), 1'b0);
    chk("ab_wr", wr, 0); chk("ab_state", st, 0); chk("ab_cap", cap, 7); chk("ab_done", done, 0);
    frame_in(DATA_W'(9), 1'b0);
    chk("ab_idle_hold", st, 0);

    // Asynchronous reset while a write is pending.
    do_arm(2'd0, 16'd0);
    frame_in(DATA_W'(1), 1'b0); frame_in(DATA_W'(2), 1'b0);
    chk("rs_pre_wr", wr, 1);
    rst_n = 1'b0; #1;
    chk("rs_wr", wr, 0); chk("rs_state", st, 0); chk("rs_cap", cap, 0);
    chk("rs_frame", frame, 0); chk("rs_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    do_arm(2'd0, 16'd2);
    chk("rs_rearm_cap", cap, 0);
    frame_in(DATA_W'(21), 1'b0);
    chk("rs_cap1", cap, 1); chk("rs_frame1", frame, 21);
    frame_in(DATA_W'(22), 1'b0);
    chk("rs_state_done", st, 3); chk("rs_done_o", done, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
